// File: rtl/bindct_pkg.sv
// -----------------------------------------------------------------------------
// bindct_pkg
// Shared constants and types for the binDCT transform path.
//   - Lifting shift amounts. Every lifting multiplier is built from these:
//       1/2 = >>>1, 1/8 = >>>3, 3/8 = >>>2 + >>>3,
//       5/8 = >>>1 + >>>3, 7/8 = >>>1 + >>>2 + >>>3
//   - Pipeline stage count and vector length.
//   - int_width(): internal datapath width (input width plus two guard bits).
//   - coef_vec_t: an 8-element coefficient vector at the default width.
// -----------------------------------------------------------------------------
package bindct_pkg;

    localparam int unsigned SH_HALF    = 1;
    localparam int unsigned SH_QUARTER = 2;
    localparam int unsigned SH_EIGHTH  = 3;

    localparam int unsigned NUM_STAGES   = 4;
    localparam int unsigned VEC_LEN      = 8;
    localparam int unsigned DEF_IN_WIDTH = 32;

    // Two guard bits absorb the growth of the lifting sums.
    function automatic int unsigned int_width(input int unsigned in_width);
        return in_width + 2;
    endfunction

    typedef logic signed [DEF_IN_WIDTH-1:0] coef_vec_t [VEC_LEN];

endpackage

// File: rtl/ibindct_halfbfly.sv
// -----------------------------------------------------------------------------
// ibindct_halfbfly
// Combinational half-butterfly: o_sum = (i_p + i_q) >>> 1,
// o_diff = (i_p - i_q) >>> 1, all arithmetic at WIDTH bits, signed.
// Ports:
//   i_p, i_q       in   signed [WIDTH-1:0]  operands
//   o_sum, o_diff  out  signed [WIDTH-1:0]  halved sum / difference
// -----------------------------------------------------------------------------
module ibindct_halfbfly #(
    parameter int unsigned WIDTH = 34
) (
    input  logic signed [WIDTH-1:0] i_p,
    input  logic signed [WIDTH-1:0] i_q,
    output logic signed [WIDTH-1:0] o_sum,
    output logic signed [WIDTH-1:0] o_diff
);

    logic signed [WIDTH-1:0] w_sum;
    logic signed [WIDTH-1:0] w_diff;

    assign w_sum  = i_p + i_q;
    assign w_diff = i_p - i_q;
    assign o_sum  = w_sum >>> 1;
    assign o_diff = w_diff >>> 1;

endmodule

// File: rtl/ibindct_32bit.sv
// -----------------------------------------------------------------------------
// ibindct_32bit
// Four-stage pipelined 8-point inverse binDCT. Each stage exactly undoes one
// forward lifting / butterfly step with the same truncating shifts.
//   S1: undo final lifting   S2: half-butterflies
//   S3: undo odd lifting     S4: half-butterflies + narrowing to OUT_WIDTH
// Build option: define IBINDCT_SAT_EN to clamp outputs to the OUT_WIDTH range;
// otherwise outputs wrap (low OUT_WIDTH bits).
// Ports:
//   clk, rst (synchronous, active-high)
//   y_in[8]/in_valid/in_ready     coefficient input, forward output order
//   x_out[8]/out_valid/out_ready  reconstructed samples x0..x7
// -----------------------------------------------------------------------------
module ibindct_32bit
    import bindct_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned INT_BITS  = 20,
    parameter int unsigned FRAC_BITS = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  y_in      [VEC_LEN],
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_WIDTH-1:0] x_out     [VEC_LEN],
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int unsigned W = int_width(IN_WIDTH);

    // The Q-format is descriptive only; the shifts do not depend on it.
    if (INT_BITS + FRAC_BITS != IN_WIDTH) begin : g_fmt_note
    end

    logic [NUM_STAGES-1:0] r_valid;
    logic signed [W-1:0]   r_c  [VEC_LEN];
    logic signed [W-1:0]   r_s2 [VEC_LEN];   // a0..a4, b1, b0, a7
    logic signed [W-1:0]   r_a  [VEC_LEN];
    logic signed [OUT_WIDTH-1:0] r_x [VEC_LEN];

    logic w_en;
    logic w_take;

    // A stall freezes every stage, empty ones included.
    assign w_en      = !r_valid[NUM_STAGES-1] || out_ready;
    assign in_ready  = w_en && !rst;
    assign w_take    = in_valid && in_ready;
    assign out_valid = r_valid[NUM_STAGES-1];
    assign x_out     = r_x;

    // ---------------- S1: undo final lifting ----------------
    logic signed [W-1:0] w_y [VEC_LEN];
    logic signed [W-1:0] w_c [VEC_LEN];

    always_comb begin
        for (int i = 0; i < VEC_LEN; i++) begin
            w_y[i] = W'(y_in[i]);
        end
        w_c    = '{default: '0};
        w_c[7] = w_y[1];
        w_c[4] = w_y[7] + (w_c[7] >>> SH_EIGHTH);
        w_c[1] = (w_y[0] >>> SH_HALF) - w_y[4];
        w_c[0] = w_y[0] - w_c[1];
        w_c[3] = w_y[2] - ((w_y[6] >>> SH_QUARTER) + (w_y[6] >>> SH_EIGHTH));
        w_c[2] = w_y[6] + ((w_c[3] >>> SH_QUARTER) + (w_c[3] >>> SH_EIGHTH));
        w_c[6] = w_y[3] + (w_y[5] >>> SH_HALF);
        w_c[5] = w_y[5] - ((w_c[6] >>> SH_HALF) + (w_c[6] >>> SH_QUARTER)
                          + (w_c[6] >>> SH_EIGHTH));
    end

    // ---------------- S2: half-butterflies ----------------
    logic signed [W-1:0] w_s2 [VEC_LEN];

    ibindct_halfbfly #(.WIDTH(W)) u_s2_03 (
        .i_p(r_c[0]), .i_q(r_c[3]), .o_sum(w_s2[0]), .o_diff(w_s2[3])
    );
    ibindct_halfbfly #(.WIDTH(W)) u_s2_12 (
        .i_p(r_c[1]), .i_q(r_c[2]), .o_sum(w_s2[1]), .o_diff(w_s2[2])
    );
    ibindct_halfbfly #(.WIDTH(W)) u_s2_45 (
        .i_p(r_c[4]), .i_q(r_c[5]), .o_sum(w_s2[4]), .o_diff(w_s2[5])
    );
    // Operand order c7,c6 so the difference lands as b0 = (c7-c6)>>>1.
    ibindct_halfbfly #(.WIDTH(W)) u_s2_76 (
        .i_p(r_c[7]), .i_q(r_c[6]), .o_sum(w_s2[7]), .o_diff(w_s2[6])
    );

    // ---------------- S3: undo odd lifting ----------------
    logic signed [W-1:0] w_a [VEC_LEN];

    always_comb begin
        w_a    = r_s2;
        // slot 5 holds b1, slot 6 holds b0
        w_a[5] = ((r_s2[6] >>> SH_HALF) + (r_s2[6] >>> SH_EIGHTH)) - r_s2[5];
        w_a[6] = r_s2[6] - ((w_a[5] >>> SH_QUARTER) + (w_a[5] >>> SH_EIGHTH));
    end

    // ---------------- S4: half-butterflies + narrowing ----------------
    logic signed [W-1:0]         w_x  [VEC_LEN];
    logic signed [OUT_WIDTH-1:0] w_xn [VEC_LEN];

    for (genvar k = 0; k < VEC_LEN / 2; k++) begin : g_s4
        ibindct_halfbfly #(.WIDTH(W)) u_s4 (
            .i_p   (r_a[k]),
            .i_q   (r_a[VEC_LEN-1-k]),
            .o_sum (w_x[k]),
            .o_diff(w_x[VEC_LEN-1-k])
        );
    end

`ifdef IBINDCT_SAT_EN
    if (OUT_WIDTH < W) begin : g_sat
        localparam logic signed [W-1:0] SAT_MAX =
            {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        localparam logic signed [W-1:0] SAT_MIN =
            {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
        always_comb begin
            for (int i = 0; i < VEC_LEN; i++) begin
                if (w_x[i] > SAT_MAX) begin
                    w_xn[i] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end else if (w_x[i] < SAT_MIN) begin
                    w_xn[i] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                end else begin
                    w_xn[i] = OUT_WIDTH'(w_x[i]);
                end
            end
        end
    end else begin : g_wide
        always_comb begin
            for (int i = 0; i < VEC_LEN; i++) begin
                w_xn[i] = OUT_WIDTH'(w_x[i]);
            end
        end
    end
`else
    // Size cast wraps when narrowing and sign-extends when widening.
    always_comb begin
        for (int i = 0; i < VEC_LEN; i++) begin
            w_xn[i] = OUT_WIDTH'(w_x[i]);
        end
    end
`endif

    // ---------------- stage registers ----------------
    // Data only loads behind a valid bit so x_out stays at its last real value
    // (or zero after reset) rather than tracking idle input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_c     <= '{default: '0};
            r_s2    <= '{default: '0};
            r_a     <= '{default: '0};
            r_x     <= '{default: '0};
        end else if (w_en) begin
            r_valid <= {r_valid[NUM_STAGES-2:0], w_take};
            if (w_take)     r_c  <= w_c;
            if (r_valid[0]) r_s2 <= w_s2;
            if (r_valid[1]) r_a  <= w_a;
            if (r_valid[2]) r_x  <= w_xn;
        end
    end

endmodule

// File: tb/tb_ibindct_32bit.sv
// -----------------------------------------------------------------------------
// tb_ibindct_32bit
// Directed bench for ibindct_32bit: reset state, exact 4-edge latency, six
// hand-computed vectors, back-to-back streaming with a 5-cycle output stall,
// reset with vectors in flight, and OUT_WIDTH=8 narrowing (wrap or clamp
// depending on IBINDCT_SAT_EN).
// -----------------------------------------------------------------------------
module tb_ibindct_32bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [31:0] y_in  [8];
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] x_out [8];
    logic               out_valid;
    logic               out_ready;

    logic signed [31:0] y8_in  [8];
    logic               in_valid8;
    logic               in_ready8;
    logic signed [7:0]  x8_out [8];
    logic               out_valid8;

    int checks = 0;
    int errors = 0;

    logic signed [31:0] ys [6][8];
    logic signed [31:0] xs [6][8];
    logic signed [31:0] zero_v [8];
    logic signed [31:0] held [8];

    ibindct_32bit dut (
        .clk      (clk),
        .rst      (rst),
        .y_in     (y_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_out    (x_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    ibindct_32bit #(.OUT_WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .y_in     (y8_in),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .x_out    (x8_out),
        .out_valid(out_valid8),
        .out_ready(1'b1)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic signed [31:0] exp_v [8]);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_x%0d", tag, i), x_out[i], exp_v[i]);
        end
    endtask

    // Entered at posedge+1; returns at posedge+1. Output must appear after
    // exactly the 4th edge counting the accepting edge.
    task automatic send_and_check(input string tag, input logic signed [31:0] yv [8],
                                  input logic signed [31:0] xv [8]);
        y_in     = yv;
        in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("%s_early%0d", tag, k), out_valid, 0);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ov"}, out_valid, 1);
        check_vec(tag, xv);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ov_once"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        int hold_seen;
        bit have_held;

        ys[0] = '{8, 0, 0, 0, 0, 0, 0, 0};   xs[0] = '{1, 1, 1, 1, 1, 1, 1, 1};
        ys[1] = '{1, 1, 1, 1, 0, 0, 0, 0};   xs[1] = '{1, 0, 0, 0, 0, 0, 0, 0};
        ys[2] = '{-8, 0, 0, 0, 0, 0, 0, 0};  xs[2] = '{-1, -1, -1, -1, -1, -1, -1, -1};
        ys[3] = '{0, 0, 0, 0, 0, 8, 0, 0};   xs[3] = '{1, -1, 0, 1, -1, -1, 1, -1};
        ys[4] = '{0, 8, 0, 0, 0, 0, 0, 0};   xs[4] = '{2, 2, 1, 0, 0, -1, -2, -2};
        ys[5] = '{0, 0, 16, 0, 0, 0, 0, 0};  xs[5] = '{4, 1, -2, -4, -4, -2, 1, 4};
        zero_v = '{default: '0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        y_in      = zero_v;
        y8_in     = zero_v;
        in_valid8 = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check_vec("rst", zero_v);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Single vectors with exact latency
        for (int v = 0; v < 6; v++) begin
            send_and_check($sformatf("vec%0d", v), ys[v], xs[v]);
        end

        // Back-to-back stream with a 5-cycle output stall
        sent      = 0;
        got       = 0;
        hold_seen = 0;
        have_held = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sent < 6) begin
                y_in     = ys[sent];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= 6 && cyc < 11);
            @(negedge clk);
            if (!out_ready && out_valid) begin
                hold_seen++;
                check("hold_in_ready", in_ready, 0);
                if (have_held) begin
                    for (int i = 0; i < 8; i++) begin
                        check($sformatf("hold_stable_x%0d", i), x_out[i], held[i]);
                    end
                end else begin
                    held      = x_out;
                    have_held = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                if (got < 6) check_vec($sformatf("stream%0d", got), xs[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, 6);
        check("stream_hold_cycles", hold_seen, 5);

        // Reset with three vectors in flight
        for (int k = 0; k < 3; k++) begin
            y_in     = ys[k + 3];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_vec("midrst", zero_v);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("midrst_ov%0d", k), out_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send_and_check("after_rst", ys[4], xs[4]);

        // Narrow output: 1600 -> 200 internally, clamps to 127 or wraps to -56
        y8_in[0]  = 1600;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("w8_ov", out_valid8, 1);
        for (int i = 0; i < 8; i++) begin
`ifdef IBINDCT_SAT_EN
            check($sformatf("w8_x%0d", i), x8_out[i], 127);
`else
            check($sformatf("w8_x%0d", i), x8_out[i], -56);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
